// File: rtl/scara_motion_sequencer.sv
// SCARA motion sequencer: buffers host commands in a FIFO and converts each move
// into per-axis step counts/directions with saturation; also handles dwell and
// set-position commands.
module scara_motion_sequencer #(
  parameter int unsigned        NUM_AXES   = 2,
  parameter int unsigned        ANGLE_W    = 13,
  parameter int unsigned        STEP_W     = 8,
  parameter int unsigned        STEP_SHIFT = 2,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter int unsigned        DWELL_W    = 13,
  parameter logic [ANGLE_W-1:0] HOME_ANGLE = 13'h0324
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_mode,
  input  logic [NUM_AXES*ANGLE_W-1:0]   cmd_angles,
  input  logic [DWELL_W-1:0]            cmd_dwell,
  input  logic                          cmd_effector,
  output logic                          step_valid,
  input  logic                          step_ready,
  output logic [NUM_AXES*STEP_W-1:0]    steps,
  output logic [NUM_AXES-1:0]           dirs,
  output logic                          effector,
  output logic                          sat_flag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [NUM_AXES*ANGLE_W-1:0]   current_angles
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 2 + NUM_AXES * ANGLE_W + DWELL_W + 1;
  localparam logic [ANGLE_W-1:0] StepMax = ANGLE_W'((1 << STEP_W) - 1);

  localparam logic [1:0] ModeAbs   = 2'b00;
  localparam logic [1:0] ModeRel   = 2'b01;
  localparam logic [1:0] ModeDwell = 2'b10;
  localparam logic [1:0] ModeSet   = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDwell} state_e;

  state_e                        state_q, state_d;
  logic                          init_q;
  logic [EntryW-1:0]             fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]               count_q;
  logic [1:0]                    wrk_mode;
  logic [NUM_AXES*ANGLE_W-1:0]   wrk_angles;
  logic [DWELL_W-1:0]            wrk_dwell;
  logic                          eff_q;
  logic [DWELL_W-1:0]            dwell_cnt_q;
  logic [NUM_AXES*STEP_W-1:0]    steps_q;
  logic [NUM_AXES-1:0]           dirs_q;
  logic                          sat_q;
  logic [NUM_AXES*ANGLE_W-1:0]   cur_q;

  logic                          push, pop;
  logic [NUM_AXES*STEP_W-1:0]    calc_steps;
  logic [NUM_AXES-1:0]           calc_dirs;
  logic                          calc_sat, calc_any;
  logic [NUM_AXES*ANGLE_W-1:0]   calc_angles;

  // cmd_ready stays low until the first edge after reset release.
  assign cmd_ready      = init_q && (count_q < CntW'(FIFO_DEPTH));
  assign push           = cmd_valid && cmd_ready;
  assign pop            = (state_q == StIdle) && (count_q != '0);
  assign step_valid     = (state_q == StIssue);
  assign steps          = steps_q;
  assign dirs           = dirs_q;
  assign effector       = eff_q;
  assign sat_flag       = sat_q;
  assign busy           = (state_q != StIdle) || (count_q != '0);
  assign fifo_count     = count_q;
  assign current_angles = cur_q;

  // FIFO storage; stale entries are harmless since pointers are reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_mode, cmd_angles, cmd_dwell, cmd_effector};
  end

  // FIFO pointers, occupancy and post-reset ready enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Per-axis move conversion: short-path delta, step magnitude with clipping.
  always_comb begin
    logic [ANGLE_W-1:0] cur, target, delta, mag, move;
    cur         = '0;
    target      = '0;
    delta       = '0;
    mag         = '0;
    move        = '0;
    calc_steps  = '0;
    calc_dirs   = '0;
    calc_sat    = 1'b0;
    calc_any    = 1'b0;
    calc_angles = cur_q;
    for (int i = 0; i < NUM_AXES; i++) begin
      cur    = cur_q[i*ANGLE_W +: ANGLE_W];
      target = (wrk_mode == ModeRel) ? cur + wrk_angles[i*ANGLE_W +: ANGLE_W]
                                     : wrk_angles[i*ANGLE_W +: ANGLE_W];
      delta  = target - cur;
      mag    = (delta[ANGLE_W-1] ? -delta : delta) >> STEP_SHIFT;
      if (mag > StepMax) begin
        mag      = StepMax;
        calc_sat = 1'b1;
      end
      calc_steps[i*STEP_W +: STEP_W] = mag[STEP_W-1:0];
      calc_dirs[i] = !delta[ANGLE_W-1] && (delta != '0);
      // Only whole steps are committed; the sub-step residual carries forward.
      move = mag << STEP_SHIFT;
      calc_angles[i*ANGLE_W +: ANGLE_W] = delta[ANGLE_W-1] ? cur - move : cur + move;
      if (mag != '0) calc_any = 1'b1;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pop) state_d = StCalc;
      StCalc: begin
        unique case (wrk_mode)
          ModeDwell: state_d = StDwell;
          ModeSet:   state_d = StIdle;
          default:   state_d = calc_any ? StIssue : StIdle;
        endcase
      end
      StIssue: if (step_ready) state_d = StIdle;
      StDwell: if (dwell_cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register plus working register, position and step outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wrk_mode    <= ModeAbs;
      wrk_angles  <= '0;
      wrk_dwell   <= '0;
      eff_q       <= 1'b0;
      dwell_cnt_q <= '0;
      steps_q     <= '0;
      dirs_q      <= '0;
      sat_q       <= 1'b0;
      cur_q       <= {NUM_AXES{HOME_ANGLE}};
    end else begin
      state_q <= state_d;
      if (pop) {wrk_mode, wrk_angles, wrk_dwell, eff_q} <= fifo_mem[rd_ptr_q];
      if (state_q == StCalc) begin
        sat_q   <= 1'b0;
        steps_q <= '0;
        dirs_q  <= '0;
        unique case (wrk_mode)
          ModeDwell: dwell_cnt_q <= wrk_dwell;
          ModeSet:   cur_q <= wrk_angles;
          default: begin
            steps_q <= calc_steps;
            dirs_q  <= calc_dirs;
            sat_q   <= calc_sat;
            cur_q   <= calc_angles;
          end
        endcase
      end
      if ((state_q == StDwell) && (dwell_cnt_q != '0)) dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
    end
  end

endmodule
